// File: rtl/lfsr_rand_gen.sv
// Galois-LFSR random source with a req/valid handshake.
// Returns a value in [0, range) by bounded rejection sampling.
module lfsr_rand_gen #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                OUT_W     = 4,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  input  logic [OUT_W-1:0]  range,
  output logic              rdy,
  output logic              valid,
  output logic [OUT_W-1:0]  rand_out,
  output logic              fail,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // An all-zero register would lock the LFSR, so fall back to SEED.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? SEED : s;
  endfunction

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt, lfsr_adv;
  logic [OUT_W-1:0]  range_q, range_nxt;
  logic [OUT_W-1:0]  cand;
  logic [OUT_W-1:0]  rand_q, rand_nxt;
  logic [TRY_W-1:0]  tries, tries_nxt;
  logic              valid_q, valid_nxt;
  logic              fail_q, fail_nxt;
  logic              hit;

  always_comb begin
    lfsr_adv = lfsr_advance(lfsr_q);
    cand     = lfsr_adv[OUT_W-1:0];
    hit      = (range_q == '0) || (cand < range_q);
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr_q;
    range_nxt = range_q;
    tries_nxt = tries;
    rand_nxt  = rand_q;
    fail_nxt  = fail_q;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (seed_load)
          lfsr_nxt = seed_fix(seed_in);
        else if (en && !req)
          lfsr_nxt = lfsr_adv;
        if (req) begin
          range_nxt = range;
          tries_nxt = '0;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (seed_load) begin
          lfsr_nxt = seed_fix(seed_in);
        end else begin
          lfsr_nxt = lfsr_adv;
          if (hit) begin
            rand_nxt  = cand;
            fail_nxt  = 1'b0;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else if (tries == LAST_TRY) begin
            rand_nxt  = '0;
            fail_nxt  = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            tries_nxt = tries + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr_q  <= SEED;
      range_q <= '0;
      tries   <= '0;
      rand_q  <= '0;
      fail_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      lfsr_q  <= lfsr_nxt;
      range_q <= range_nxt;
      tries   <= tries_nxt;
      rand_q  <= rand_nxt;
      fail_q  <= fail_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign rdy        = (state == IDLE);
  assign valid      = valid_q;
  assign rand_out   = rand_q;
  assign fail       = fail_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen with hand-computed LFSR sequences
// from the default 16-bit polynomial and seed.
module tb_lfsr_rand_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;
  logic [3:0]  range;
  logic        rdy;
  logic        valid;
  logic [3:0]  rand_out;
  logic        fail;
  logic [15:0] lfsr_state;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int edges;
  int vc0;

  lfsr_rand_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .range(range), .rdy(rdy), .valid(valid), .rand_out(rand_out),
    .fail(fail), .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) valid_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    tick();
    rst_n = 1'b1;
  endtask

  // Pulse req for one edge and count edges (including the accepting one) until valid.
  task automatic do_req(input logic [3:0] rng, output int n);
    req   = 1'b1;
    range = rng;
    tick();
    req   = 1'b0;
    n = 1;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = '0; req = 1'b0; range = '0;
    #2;
    rst_n = 1'b0;
    #2;
    check("rst_state", 32'(lfsr_state), 32'hACE1);
    check("rst_rdy",   32'(rdy),        32'd1);
    check("rst_valid", 32'(valid),      32'd0);
    check("rst_fail",  32'(fail),       32'd0);
    check("rst_rand",  32'(rand_out),   32'd0);
    tick();
    rst_n = 1'b1;

    // Full-span request: first draw accepted.
    do_req(4'd0, edges);
    check("t1_lat",   32'(edges),      32'd2);
    check("t1_rand",  32'(rand_out),   32'h0);
    check("t1_fail",  32'(fail),       32'd0);
    check("t1_state", 32'(lfsr_state), 32'hE270);
    check("t1_rdy",   32'(rdy),        32'd1);
    tick();
    check("t1_pulse", 32'(valid),      32'd0);

    // range=5: 8,C,E,7 rejected, 3 accepted.
    do_req(4'd5, edges);
    check("t2_lat",   32'(edges),      32'd6);
    check("t2_rand",  32'(rand_out),   32'h3);
    check("t2_fail",  32'(fail),       32'd0);
    check("t2_state", 32'(lfsr_state), 32'hB313);
    tick();
    check("t2_hold",  32'(rand_out),   32'h3);

    // range=1 after one draw: eight rejections, give up.
    do_reset();
    do_req(4'd5, edges);
    check("t3a_rand", 32'(rand_out),   32'h0);
    do_req(4'd1, edges);
    check("t3_lat",   32'(edges),      32'd9);
    check("t3_fail",  32'(fail),       32'd1);
    check("t3_rand",  32'(rand_out),   32'h0);
    check("t3_state", 32'(lfsr_state), 32'h6162);

    // Free-run advance while idle.
    do_reset();
    en = 1'b1;
    tick(); tick(); tick();
    en = 1'b0;
    check("t4_state", 32'(lfsr_state), 32'h389C);
    do_req(4'd0, edges);
    check("t4_lat",   32'(edges),      32'd2);
    check("t4_rand",  32'(rand_out),   32'hE);
    check("t4_state2",32'(lfsr_state), 32'h1C4E);

    // Seed load, zero-seed fallback, and reload mid-draw.
    load_seed(16'hE270);
    check("t5_load",  32'(lfsr_state), 32'hE270);
    load_seed(16'h0000);
    check("t5_zero",  32'(lfsr_state), 32'hACE1);
    load_seed(16'hE270);
    req = 1'b1; range = 4'd1;
    tick();
    req = 1'b0;
    tick();
    check("t5_draw1", 32'(lfsr_state), 32'h7138);
    check("t5_nov1",  32'(valid),      32'd0);
    seed_load = 1'b1; seed_in = 16'h0001;
    tick();
    seed_load = 1'b0;
    check("t5_seedd", 32'(lfsr_state), 32'h0001);
    check("t5_nov2",  32'(valid),      32'd0);
    tick();
    check("t5_valid", 32'(valid),      32'd1);
    check("t5_state", 32'(lfsr_state), 32'hB400);
    check("t5_rand",  32'(rand_out),   32'h0);
    check("t5_fail",  32'(fail),       32'd0);

    // Reset in the middle of a draw aborts it.
    load_seed(16'hE270);
    vc0 = valid_cnt;
    req = 1'b1; range = 4'd1;
    tick();
    req = 1'b0;
    tick();
    tick();
    check("t6_busy",  32'(rdy),        32'd0);
    rst_n = 1'b0;
    #2;
    check("t6_rdy",   32'(rdy),        32'd1);
    check("t6_valid", 32'(valid),      32'd0);
    check("t6_state", 32'(lfsr_state), 32'hACE1);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t6_novalid", 32'(valid_cnt - vc0), 32'd0);

    // req held high during DRAW is not queued.
    load_seed(16'hE270);
    vc0 = valid_cnt;
    req = 1'b1; range = 4'd5;
    edges = 0;
    tick();
    while (!valid && edges < 40) begin
      tick();
      edges++;
    end
    req = 1'b0;
    check("t7_lat",   32'(edges),      32'd5);
    check("t7_rand",  32'(rand_out),   32'h3);
    for (int i = 0; i < 10; i++) tick();
    check("t7_single",32'(valid_cnt - vc0), 32'd1);
    check("t7_rdy",   32'(rdy),        32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
